// File: rtl/voltage_uart_framer_if.sv
`default_nettype none
// ============================================================================
// Module      : voltage_uart_framer_if
// Description : Bundles the ADC voltage word, the uart TX FIFO handshake and
//               the framer status pulses into one interface.
//               master = framer side, slave = ADC/uart/system side.
//   in        [15:0]  BCD voltage word d.ddd (units..thousandths)
//   tx_full           uart TX FIFO full
//   w_data    [7:0]   ASCII byte to uart, qualified by wr_uart
//   wr_uart           one-cycle FIFO write strobe
//   busy              frame in progress
//   bad_digit         pulse: snapshot held a nibble > 9
//   overrun           pulse: a period request was dropped
// Revision    : 1.0  initial release
// ============================================================================
interface voltage_uart_framer_if;
  logic [15:0] in;
  logic        tx_full;
  logic [7:0]  w_data;
  logic        wr_uart;
  logic        busy;
  logic        bad_digit;
  logic        overrun;

  modport master (
    input  in,
    input  tx_full,
    output w_data,
    output wr_uart,
    output busy,
    output bad_digit,
    output overrun
  );

  modport slave (
    output in,
    output tx_full,
    input  w_data,
    input  wr_uart,
    input  busy,
    input  bad_digit,
    input  overrun
  );
endinterface
`default_nettype wire

// File: rtl/voltage_uart_framer.sv
`default_nettype none
// ============================================================================
// Module      : voltage_uart_framer
// Description : Every PERIOD_CYCLES clocks, snapshots the BCD voltage word and
//               writes the 9-byte ASCII frame "d.ddd V\r\n" into the uart TX
//               FIFO, honouring tx_full back-pressure. One request may be held
//               pending while a frame is in flight; further ones are dropped
//               and flagged with overrun.
// Ports       : clk  - system clock
//               rst  - asynchronous active-high reset
//               bus  - voltage_uart_framer_if.master (in, tx_full, w_data,
//                      wr_uart, busy, bad_digit, overrun)
// Revision    : 1.0  initial release
// ============================================================================
module voltage_uart_framer #(
  parameter int PERIOD_CYCLES = 10_000_000
) (
  input  wire logic               clk,
  input  wire logic               rst,
  voltage_uart_framer_if.master   bus
);

  localparam int                 CNT_W     = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0]   C_CNT_MAX = CNT_W'(PERIOD_CYCLES - 1);
  localparam logic [3:0]         C_IDX_LAST = 4'd8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t             state_q,     state_d;
  logic [CNT_W-1:0]   cnt_q,       cnt_d;
  logic               pending_q,   pending_d;
  logic [15:0]        snap_q,      snap_d;
  logic [3:0]         idx_q,       idx_d;
  logic [7:0]         w_data_q,    w_data_d;
  logic               wr_uart_q,   wr_uart_d;
  logic               busy_q,      busy_d;
  logic               bad_digit_q, bad_digit_d;
  logic               overrun_q,   overrun_d;

  logic               tick;
  logic [7:0]         frame_byte;

  // BCD nibble to ASCII digit; anything outside 0..9 is shown as '?'.
  function automatic logic [7:0] ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic logic any_bad(input logic [15:0] w);
    return (w[15:12] > 4'd9) || (w[11:8] > 4'd9) ||
           (w[7:4]   > 4'd9) || (w[3:0]  > 4'd9);
  endfunction

  assign tick = (cnt_q == C_CNT_MAX);

  always_comb begin
    frame_byte = 8'h0A;
    case (idx_q)
      4'd0:    frame_byte = ascii(snap_q[15:12]);
      4'd1:    frame_byte = 8'h2E;
      4'd2:    frame_byte = ascii(snap_q[11:8]);
      4'd3:    frame_byte = ascii(snap_q[7:4]);
      4'd4:    frame_byte = ascii(snap_q[3:0]);
      4'd5:    frame_byte = 8'h20;
      4'd6:    frame_byte = 8'h56;
      4'd7:    frame_byte = 8'h0D;
      default: frame_byte = 8'h0A;
    endcase
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = tick ? '0 : cnt_q + CNT_W'(1);
    pending_d   = pending_q;
    snap_d      = snap_q;
    idx_d       = idx_q;
    w_data_d    = w_data_q;
    wr_uart_d   = 1'b0;
    busy_d      = busy_q;
    bad_digit_d = 1'b0;
    overrun_d   = 1'b0;

    // A tick arriving mid-frame is remembered once; a second one is lost.
    if (tick && (state_q != IDLE)) begin
      if (pending_q) begin
        overrun_d = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        // tick and pending together are a single request
        if (tick || pending_q) begin
          snap_d      = bus.in;
          idx_d       = 4'd0;
          busy_d      = 1'b1;
          pending_d   = 1'b0;
          bad_digit_d = any_bad(bus.in);
          state_d     = WRITE;
        end
      end
      WRITE: begin
        if (!bus.tx_full) begin
          wr_uart_d = 1'b1;
          w_data_d  = frame_byte;
          state_d   = SETTLE;
        end
      end
      SETTLE: begin
        // The idle cycle between writes lets the FIFO's registered full flag
        // catch up before the next write decision.
        if (idx_q == C_IDX_LAST) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 4'd1;
          state_d = WRITE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pending_q   <= 1'b0;
      snap_q      <= 16'h0000;
      idx_q       <= 4'd0;
      w_data_q    <= 8'h00;
      wr_uart_q   <= 1'b0;
      busy_q      <= 1'b0;
      bad_digit_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      snap_q      <= snap_d;
      idx_q       <= idx_d;
      w_data_q    <= w_data_d;
      wr_uart_q   <= wr_uart_d;
      busy_q      <= busy_d;
      bad_digit_q <= bad_digit_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.w_data    = w_data_q;
  assign bus.wr_uart   = wr_uart_q;
  assign bus.busy      = busy_q;
  assign bus.bad_digit = bad_digit_q;
  assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_voltage_uart_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_voltage_uart_framer
// Description : Directed self-checking bench for voltage_uart_framer with a
//               short period so several frames fit in a short run.
// Revision    : 1.0  initial release
// ============================================================================
module tb_voltage_uart_framer;

  localparam int P = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  voltage_uart_framer_if bus();

  voltage_uart_framer #(.PERIOD_CYCLES(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // strobe log: data and cycle number of every wr_uart
  logic [7:0] mon_data [$];
  int         mon_cyc  [$];
  always @(negedge clk) begin
    if (bus.wr_uart) begin
      mon_data.push_back(bus.w_data);
      mon_cyc.push_back(cyc);
    end
  end

  logic [7:0] E1234 [9] = '{8'h31, 8'h2E, 8'h32, 8'h33, 8'h34, 8'h20, 8'h56, 8'h0D, 8'h0A};
  logic [7:0] E0999 [9] = '{8'h30, 8'h2E, 8'h39, 8'h39, 8'h39, 8'h20, 8'h56, 8'h0D, 8'h0A};
  logic [7:0] E9A0F [9] = '{8'h39, 8'h2E, 8'h3F, 8'h30, 8'h3F, 8'h20, 8'h56, 8'h0D, 8'h0A};

  // one cycle, then settle past the monitor's negedge sample
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    mon_data.delete();
    mon_cyc.delete();
  endtask

  task automatic wait_rise(output int c, output bit ok);
    logic prev;
    prev = bus.busy;
    ok = 1'b0;
    c = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.busy && !prev) begin
        c = cyc;
        ok = 1'b1;
        break;
      end
      prev = bus.busy;
    end
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mon_data.size() >= n) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (!bus.busy) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    bus.in = 16'h1234;
    bus.tx_full = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    n_checks++; if (bus.wr_uart !== 1'b0) begin n_errors++; $display("FAIL reset_wr_uart: got %b expected 0", bus.wr_uart); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.w_data !== 8'h00) begin n_errors++; $display("FAIL reset_w_data: got %h expected 00", bus.w_data); end
    n_checks++; if (bus.bad_digit !== 1'b0) begin n_errors++; $display("FAIL reset_bad_digit: got %b expected 0", bus.bad_digit); end
    n_checks++; if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b expected 0", bus.overrun); end
    rst = 1'b0;
  endtask

  // T1: frame content, strobe spacing, busy length, period
  task automatic test_frame();
    int b0, b1, hi;
    bit ok;
    wait_rise(b0, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL t1_start: got timeout expected busy rise"); return; end
    clear_log();
    n_checks++; if (bus.bad_digit !== 1'b0) begin n_errors++; $display("FAIL t1_bad_digit: got %b expected 0", bus.bad_digit); end
    hi = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.busy) hi++;
    end
    n_checks++; if (hi !== 18) begin n_errors++; $display("FAIL t1_busy_len: got %0d expected 18", hi); end
    n_checks++; if (mon_data.size() !== 9) begin n_errors++; $display("FAIL t1_count: got %0d expected 9", mon_data.size()); end
    for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== E1234[i]) begin n_errors++; $display("FAIL t1_byte[%0d]: got %h expected %h", i, mon_data[i], E1234[i]); end
      n_checks++; if (mon_cyc[i] !== b0 + 1 + 2 * i) begin n_errors++; $display("FAIL t1_time[%0d]: got %0d expected %0d", i, mon_cyc[i], b0 + 1 + 2 * i); end
    end
    wait_rise(b1, ok);
    n_checks++; if (!ok || b1 !== b0 + P) begin n_errors++; $display("FAIL t1_period: got %0d expected %0d", b1 - b0, P); end
  endtask

  // T2: snapshot is frozen while the frame is sent (entered right at a busy rise)
  task automatic test_snapshot();
    int b;
    bit ok;
    clear_log();
    wait_log(3, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL t2_progress: got timeout expected 3 bytes"); return; end
    bus.in = 16'h0999;
    wait_idle(ok);
    n_checks++; if (mon_data.size() !== 9) begin n_errors++; $display("FAIL t2_count_a: got %0d expected 9", mon_data.size()); end
    for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== E1234[i]) begin n_errors++; $display("FAIL t2_old_byte[%0d]: got %h expected %h", i, mon_data[i], E1234[i]); end
    end
    wait_rise(b, ok);
    clear_log();
    repeat (20) step();
    n_checks++; if (mon_data.size() !== 9) begin n_errors++; $display("FAIL t2_count_b: got %0d expected 9", mon_data.size()); end
    for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== E0999[i]) begin n_errors++; $display("FAIL t2_new_byte[%0d]: got %h expected %h", i, mon_data[i], E0999[i]); end
    end
  endtask

  // T3: 40-cycle stall at idx=3
  task automatic test_backpressure();
    int b, lo;
    bit ok;
    wait_rise(b, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL t3_start: got timeout expected busy rise"); return; end
    clear_log();
    wait_log(3, ok);
    bus.tx_full = 1'b1;
    lo = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (!bus.busy) lo++;
    end
    n_checks++; if (mon_data.size() !== 3) begin n_errors++; $display("FAIL t3_stall_writes: got %0d expected 3", mon_data.size()); end
    n_checks++; if (lo !== 0) begin n_errors++; $display("FAIL t3_stall_busy: got %0d idle cycles expected 0", lo); end
    bus.tx_full = 1'b0;
    wait_idle(ok);
    n_checks++; if (mon_data.size() !== 9) begin n_errors++; $display("FAIL t3_count: got %0d expected 9", mon_data.size()); end
    for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== E0999[i]) begin n_errors++; $display("FAIL t3_byte[%0d]: got %h expected %h", i, mon_data[i], E0999[i]); end
    end
  endtask

  // T4: non-BCD nibbles
  task automatic test_bad_digit();
    int b, pulses;
    bit ok;
    bus.in = 16'h9A0F;
    wait_rise(b, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL t4_start: got timeout expected busy rise"); return; end
    clear_log();
    n_checks++; if (bus.bad_digit !== 1'b1) begin n_errors++; $display("FAIL t4_bad_digit_at_start: got %b expected 1", bus.bad_digit); end
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.bad_digit) pulses++;
    end
    n_checks++; if (pulses !== 0) begin n_errors++; $display("FAIL t4_bad_digit_extra: got %0d expected 0", pulses); end
    n_checks++; if (mon_data.size() !== 9) begin n_errors++; $display("FAIL t4_count: got %0d expected 9", mon_data.size()); end
    for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== E9A0F[i]) begin n_errors++; $display("FAIL t4_byte[%0d]: got %h expected %h", i, mon_data[i], E9A0F[i]); end
    end
  endtask

  // T5: stall across two ticks -> one pending, one overrun, then back-to-back frame
  task automatic test_overrun();
    int b, pulses, pc;
    bit ok;
    bus.in = 16'h1234;
    wait_rise(b, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL t5_start: got timeout expected busy rise"); return; end
    bus.tx_full = 1'b1;
    clear_log();
    pulses = 0;
    pc = 0;
    for (int i = 0; i < 140; i++) begin
      step();
      if (bus.overrun) begin
        pulses++;
        pc = cyc;
      end
    end
    n_checks++; if (pulses !== 1) begin n_errors++; $display("FAIL t5_overrun_count: got %0d expected 1", pulses); end
    n_checks++; if (pc !== b + 2 * P) begin n_errors++; $display("FAIL t5_overrun_time: got %0d expected %0d", pc - b, 2 * P); end
    n_checks++; if (mon_data.size() !== 0) begin n_errors++; $display("FAIL t5_stall_writes: got %0d expected 0", mon_data.size()); end
    bus.tx_full = 1'b0;
    wait_idle(ok);
    step();
    n_checks++; if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL t5_no_gap: got busy %b expected 1", bus.busy); end
    wait_idle(ok);
    n_checks++; if (mon_data.size() !== 18) begin n_errors++; $display("FAIL t5_count: got %0d expected 18", mon_data.size()); end
    if (mon_data.size() >= 10) begin
      n_checks++; if (mon_data[9] !== 8'h31) begin n_errors++; $display("FAIL t5_second_first_byte: got %h expected 31", mon_data[9]); end
    end
  endtask

  // T6: reset asserted while idx=5 is being written
  task automatic test_reset_midframe();
    int b, r;
    bit ok;
    wait_rise(b, ok);
    n_checks++; if (!ok) begin n_errors++; $display("FAIL t6_start: got timeout expected busy rise"); return; end
    clear_log();
    wait_log(6, ok);
    rst = 1'b1;
    #1;
    n_checks++; if (bus.wr_uart !== 1'b0) begin n_errors++; $display("FAIL t6_async_wr_uart: got %b expected 0", bus.wr_uart); end
    n_checks++; if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL t6_async_busy: got %b expected 0", bus.busy); end
    repeat (3) step();
    rst = 1'b0;
    r = cyc;
    clear_log();
    wait_log(1, ok);
    n_checks++; if (!ok || mon_cyc[0] !== r + P + 1) begin n_errors++; $display("FAIL t6_first_byte_time: got %0d expected %0d", ok ? mon_cyc[0] - r : -1, P + 1); end
    wait_idle(ok);
    n_checks++; if (mon_data.size() !== 9) begin n_errors++; $display("FAIL t6_count: got %0d expected 9", mon_data.size()); end
    for (int i = 0; i < 9 && i < mon_data.size(); i++) begin
      n_checks++; if (mon_data[i] !== E1234[i]) begin n_errors++; $display("FAIL t6_byte[%0d]: got %h expected %h", i, mon_data[i], E1234[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_snapshot();
    test_backpressure();
    test_bad_digit();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
